braille_read_scheduler: RTL

BRAILLE_READ_SCHEDULER -- requirements
Module: braille_read_scheduler

---
 rtl/braille_read_scheduler.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/braille_read_scheduler.sv
// Round-robin scheduler that lets two braille readers share one cell converter.
// Optional macro BRAILLE_SCHED_REQ_SYNC_EN adds a 2-flop synchronizer on each req bit.
//
// state   | meaning
// S_IDLE  | sample requests, arbitrate, load grant
// S_ISSUE | next_out high for one cycle, load wait_cnt
// S_WAIT  | count down converter latency
// S_LATCH | cell_in valid; capture into granted reader
// S_DWELL | hold off before the next grant
module braille_read_scheduler #(
  parameter int CONV_LAT = 2,
  parameter int DWELL    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [7:0] cell_in,
  output logic       next_out,
  output logic [1:0] grant,
  output logic [7:0] reader0_out,
  output logic [7:0] reader1_out,
  output logic [1:0] done,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_LATCH,
    S_DWELL
  } state_t;

  localparam logic [3:0] WAIT_LOAD  = 4'(CONV_LAT - 1);
  localparam logic [7:0] DWELL_LOAD = (DWELL > 0) ? 8'(DWELL - 1) : 8'd0;
  localparam bit         HAS_WAIT   = (CONV_LAT > 1);
  localparam bit         HAS_DWELL  = (DWELL > 0);

  state_t     r_state;
  logic       r_next;
  logic [1:0] r_grant;
  logic [1:0] r_done;
  logic       r_busy;
  logic [7:0] r_reader0;
  logic [7:0] r_reader1;
  logic [3:0] r_wait_cnt;
  logic [7:0] r_dwell_cnt;
  logic       r_last_served;   // 1 = reader1 was served last

  logic [1:0] w_req;
  logic [1:0] w_pick;

`ifdef BRAILLE_SCHED_REQ_SYNC_EN
  logic [1:0] r_req_s1;
  logic [1:0] r_req_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req_s1 <= 2'b00;
      r_req_s2 <= 2'b00;
    end else begin
      r_req_s1 <= req;
      r_req_s2 <= r_req_s1;
    end
  end

  assign w_req = r_req_s2;
`else
  assign w_req = req;
`endif

  always_comb begin
    w_pick = 2'b00;
    case (w_req)
      2'b01:   w_pick = 2'b01;
      2'b10:   w_pick = 2'b10;
      2'b11:   w_pick = r_last_served ? 2'b01 : 2'b10;
      default: w_pick = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_next        <= 1'b0;
      r_grant       <= 2'b00;
      r_done        <= 2'b00;
      r_busy        <= 1'b0;
      r_reader0     <= 8'h00;
      r_reader1     <= 8'h00;
      r_wait_cnt    <= 4'd0;
      r_dwell_cnt   <= 8'd0;
      r_last_served <= 1'b1;
    end else begin
      r_next <= 1'b0;
      r_done <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (w_pick != 2'b00) begin
            r_grant <= w_pick;
            r_next  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wait_cnt <= WAIT_LOAD;
          r_state    <= HAS_WAIT ? S_WAIT : S_LATCH;
        end
        S_WAIT: begin
          // WAIT lasts CONV_LAT-1 cycles; the counter reaches 0 as LATCH is entered
          if (r_wait_cnt <= 4'd1) begin
            r_wait_cnt <= 4'd0;
            r_state    <= S_LATCH;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        S_LATCH: begin
          if (r_grant == 2'b01) r_reader0 <= cell_in;
          if (r_grant == 2'b10) r_reader1 <= cell_in;
          r_done        <= r_grant;
          r_last_served <= r_grant[1];
          if (HAS_DWELL) begin
            r_dwell_cnt <= DWELL_LOAD;
            r_state     <= S_DWELL;
          end else begin
            r_grant <= 2'b00;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_DWELL: begin
          if (r_dwell_cnt == 8'd0) begin
            r_grant <= 2'b00;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_dwell_cnt <= r_dwell_cnt - 8'd1;
          end
        end
        default: begin
          r_grant <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign next_out    = r_next;
  assign grant       = r_grant;
  assign done        = r_done;
  assign busy        = r_busy;
  assign reader0_out = r_reader0;
  assign reader1_out = r_reader1;

endmodule
